// File: rtl/alu_exec.sv
// jacaranda-8 execute unit: 8-bit ALU with iterative one-bit-per-cycle shifts.
// Valid/ready on both sides; results are held until the consumer takes them.
module alu_exec #(
  parameter int WIDTH     = 8,
  parameter int MAX_SHAMT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] rd_val,
  input  logic [WIDTH-1:0] rs_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             err
);

  localparam int CW = $clog2(MAX_SHAMT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SK_SLL,
    SK_SRL,
    SK_SRA
  } shk_e;

  state_e          state_q, state_d;
  shk_e            shk_q, shk_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zf_q, zf_d;
  logic            cf_q, cf_d;
  logic            err_q, err_d;

  logic [WIDTH:0]  sum;
  logic [CW-1:0]   shamt;

  assign sum = {1'b0, rd_val} + {1'b0, rs_val};

  // Shift amount from the low nibble, clamped to the register width.
  always_comb begin
    shamt = rs_val[CW-1:0];
    if (rs_val[CW-1:0] > CW'(MAX_SHAMT)) shamt = CW'(MAX_SHAMT);
  end

  // Next-state: accept and compute in IDLE, step shifts, release on handshake.
  always_comb begin
    state_d = state_q;
    shk_d   = shk_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          cf_d    = 1'b0;
          err_d   = 1'b0;
          unique case (alu_ctrl)
            4'b0000: begin
              res_d = sum[WIDTH-1:0];
              cf_d  = sum[WIDTH];
            end
            4'b0001: begin
              res_d = rd_val - rs_val;
              cf_d  = (rd_val < rs_val);
            end
            4'b0010: res_d = rd_val & rs_val;
            4'b0011: res_d = rd_val | rs_val;
            4'b0100: res_d = ~rd_val;
            4'b0101, 4'b0110, 4'b0111: begin
              res_d = rd_val;
              unique case (alu_ctrl[1:0])
                2'b01:   shk_d = SK_SLL;
                2'b10:   shk_d = SK_SRL;
                default: shk_d = SK_SRA;
              endcase
              if (shamt != '0) begin
                state_d = S_SHIFT;
                cnt_d   = shamt;
              end
            end
            4'b1000: res_d = rs_val;
            default: begin
              res_d = '0;
              err_d = 1'b1;
            end
          endcase
          zf_d = ~|res_d;
        end
      end
      S_SHIFT: begin
        unique case (shk_q)
          SK_SLL: begin
            cf_d  = res_q[WIDTH-1];
            res_d = {res_q[WIDTH-2:0], 1'b0};
          end
          SK_SRL: begin
            cf_d  = res_q[0];
            res_d = {1'b0, res_q[WIDTH-1:1]};
          end
          default: begin
            cf_d  = res_q[0];
            res_d = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
          end
        endcase
        cnt_d = cnt_q - 1'b1;
        zf_d  = ~|res_d;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shk_q   <= SK_SLL;
      res_q   <= '0;
      cnt_q   <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shk_q   <= shk_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign err       = err_q;

endmodule
